fdtd_ez_update_pipe: RTL and testbench

//  Streaming, parametrised 1-D FDTD Ez update engine:
//    Ez_new[k] = ceze*Ez_old[k] + cezhy*(Hy[k] - Hy[k-1])

---
 rtl/fdtd_ez_update_pipe_if.sv | 27 ++
 rtl/fdtd_ez_update_pipe.sv | 138 +++++++++++++
 tb/tb_fdtd_ez_update_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdtd_ez_update_pipe_if.sv
// rtl/fdtd_ez_update_pipe_if.sv - input/output beat bundle for the FDTD Ez update pipe
interface fdtd_ez_update_pipe_if #(
  parameter int W = 32
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_hy;
  logic [W-1:0] s_ez;
  logic [W-1:0] s_cezhy;
  logic [W-1:0] s_ceze;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_ez;
  logic         m_last;
  logic         m_sat;

  modport slave (
    input  s_valid, s_hy, s_ez, s_cezhy, s_ceze, s_last, m_ready,
    output s_ready, m_valid, m_ez, m_last, m_sat
  );

  modport master (
    output s_valid, s_hy, s_ez, s_cezhy, s_ceze, s_last, m_ready,
    input  s_ready, m_valid, m_ez, m_last, m_sat
  );
endinterface

// File: rtl/fdtd_ez_update_pipe.sv
// rtl/fdtd_ez_update_pipe.sv - streaming 1-D FDTD Ez update pipe with PEC left wall and row checking
// Define FDTD_EZ_SAT_EN to clip out-of-range results (and flag m_sat) instead of wrapping.
module fdtd_ez_update_pipe #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int FRAC_BITS       = 16,
  parameter int NCELL           = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  fdtd_ez_update_pipe_if.slave io_s,
  output logic                 o_row_err
);
  localparam int W  = FDTD_DATA_WIDTH;
  localparam int CW = (NCELL > 2) ? $clog2(NCELL) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(NCELL - 1);

  logic                  w_en;
  logic                  w_accept;
  logic                  w_cell0;
  logic                  w_at_last;
  logic [W-1:0]          w_hy_prev;
  logic [W:0]            w_diff;
  logic signed [2*W-1:0] w_pe;
  logic signed [2*W:0]   w_ph;
  logic signed [2*W+1:0] w_sum;
  logic signed [2*W+1:0] w_shift;
  logic [W-1:0]          w_out_ez;
  logic                  w_out_sat;

  logic [CW-1:0]         r_cell_cnt;
  logic [W-1:0]          r_hy_prev;
  logic                  r_row_err;
  logic                  r1_valid, r1_last;
  logic [W:0]            r1_diff;
  logic [W-1:0]          r1_ez, r1_ceze, r1_cezhy;
  logic                  r2_valid, r2_last;
  logic signed [2*W-1:0] r2_pe;
  logic signed [2*W:0]   r2_ph;
  logic                  r3_valid, r3_last;
  logic signed [2*W+1:0] r3_sum;
  logic                  r_out_valid, r_out_last, r_out_sat;
  logic [W-1:0]          r_out_ez;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign w_en      = io_s.m_ready | ~r_out_valid;
  assign w_accept  = io_s.s_valid & w_en & ~i_clr;
  assign w_cell0   = (r_cell_cnt == '0);
  assign w_at_last = (r_cell_cnt == LAST_CELL);
  assign w_hy_prev = w_cell0 ? '0 : r_hy_prev;
  assign w_diff    = {io_s.s_hy[W-1], io_s.s_hy} - {w_hy_prev[W-1], w_hy_prev};

  assign w_pe    = $signed({{W{r1_ez[W-1]}}, r1_ez}) * $signed({{W{r1_ceze[W-1]}}, r1_ceze});
  assign w_ph    = $signed({{W{r1_diff[W]}}, r1_diff}) * $signed({{(W+1){r1_cezhy[W-1]}}, r1_cezhy});
  assign w_sum   = $signed({{2{r2_pe[2*W-1]}}, r2_pe}) + $signed({r2_ph[2*W], r2_ph});
  assign w_shift = r3_sum >>> FRAC_BITS;

`ifdef FDTD_EZ_SAT_EN
  logic w_fits;
  assign w_fits = (w_shift[2*W+1:W-1] == '0) || (&w_shift[2*W+1:W-1]);
  always_comb begin
    w_out_sat = ~w_fits;
    w_out_ez  = w_shift[W-1:0];
    if (!w_fits) begin
      w_out_ez = w_shift[2*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_out_ez  = w_shift[W-1:0];
  assign w_out_sat = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cell_cnt  <= '0;
      r_hy_prev   <= '0;
      r_row_err   <= 1'b0;
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ez    <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
    end else if (i_clr) begin
      r_cell_cnt  <= '0;
      r_hy_prev   <= '0;
      r_row_err   <= 1'b0;
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ez    <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hy_prev  <= io_s.s_hy;
        r_cell_cnt <= (io_s.s_last || w_at_last) ? '0 : r_cell_cnt + 1'b1;
        // Row length mismatch in either direction is sticky until reset/clear.
        if (io_s.s_last != w_at_last) begin
          r_row_err <= 1'b1;
        end
      end
      if (w_en) begin
        r1_valid    <= w_accept;
        r2_valid    <= r1_valid;
        r3_valid    <= r2_valid;
        r_out_valid <= r3_valid;
        r_out_ez    <= w_out_ez;
        r_out_last  <= r3_last;
        r_out_sat   <= w_out_sat & r3_valid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      r1_diff  <= w_diff;
      r1_ez    <= io_s.s_ez;
      r1_ceze  <= io_s.s_ceze;
      r1_cezhy <= io_s.s_cezhy;
      r1_last  <= io_s.s_last;
      r2_pe    <= w_pe;
      r2_ph    <= w_ph;
      r2_last  <= r1_last;
      r3_sum   <= w_sum;
      r3_last  <= r2_last;
    end
  end

  assign io_s.s_ready = w_en & ~i_clr;
  assign io_s.m_valid = r_out_valid;
  assign io_s.m_ez    = r_out_ez;
  assign io_s.m_last  = r_out_last;
  assign io_s.m_sat   = r_out_sat;
  assign o_row_err    = r_row_err;
endmodule

// File: tb/tb_fdtd_ez_update_pipe.sv
// tb/tb_fdtd_ez_update_pipe.sv - directed self-checking bench for fdtd_ez_update_pipe (W=32, FRAC=16, NCELL=4)
module tb_fdtd_ez_update_pipe;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;

  logic clk;
  logic rst;
  logic clr;
  logic row_err;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   t_acc;
  int   t_first;
  int   t_valid;
  bit   seen_valid;
  bit   toggle_en;
  int   tidx;
  bit [3:0] pat;
  int   glitch;
  bit   prev_stall;
  logic [31:0] held_ez;
  logic        held_last;
  logic [31:0] q_ez[$];
  logic        q_last[$];
  logic        q_sat[$];

  fdtd_ez_update_pipe_if #(.W(32)) bus ();

  fdtd_ez_update_pipe #(
    .FDTD_DATA_WIDTH(32),
    .FRAC_BITS(16),
    .NCELL(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_clr(clr),
    .io_s(bus),
    .o_row_err(row_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        t_valid    = cyc;
      end
      if (prev_stall && bus.m_valid && (bus.m_ez !== held_ez || bus.m_last !== held_last)) glitch++;
      prev_stall = bus.m_valid & ~bus.m_ready;
      held_ez    = bus.m_ez;
      held_last  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        q_ez.push_back(bus.m_ez);
        q_last.push_back(bus.m_last);
        q_sat.push_back(bus.m_sat);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    pat  = 4'b1001;
    tidx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        bus.m_ready = pat[tidx];
        tidx        = (tidx + 1) % 4;
      end
    end
  end

  task automatic send(input logic [31:0] hy, input logic [31:0] ez, input logic [31:0] cezhy,
                      input logic [31:0] ceze, input logic last);
    int   guard;
    logic acc;
    bus.s_valid = 1'b1;
    bus.s_hy    = hy;
    bus.s_ez    = ez;
    bus.s_cezhy = cezhy;
    bus.s_ceze  = ceze;
    bus.s_last  = last;
    guard       = 0;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 40);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", guard);
    end
    t_acc = cyc;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input int n);
    int guard;
    bus.s_valid = 1'b0;
    guard = 0;
    while (q_ez.size() < n && guard < 80) begin
      @(posedge clk);
      #1;
      guard++;
    end
    idle(4);
  endtask

  task automatic clear_q();
    q_ez.delete();
    q_last.delete();
    q_sat.delete();
  endtask

  task automatic test_reset();
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
    n_tests++; if (bus.m_ez !== 32'h0) begin n_fail++; $display("FAIL reset_m_ez: got %h, required 0", bus.m_ez); end
    n_tests++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b, required 0", bus.m_last); end
    n_tests++; if (bus.m_sat !== 1'b0) begin n_fail++; $display("FAIL reset_m_sat: got %b, required 0", bus.m_sat); end
    n_tests++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL reset_row_err: got %b, required 0", row_err); end
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 1", bus.s_ready); end
  endtask

  task automatic send_row1();
    send(32'h2_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h1_0000, 32'h0, HALF, ONE, 1'b1);
  endtask

  task automatic test_basic_row();
    logic [31:0] exp_ez [4] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_0000};
    clear_q();
    seen_valid = 1'b0;
    send(32'h2_0000, 32'h0, HALF, ONE, 1'b0);
    t_first = t_acc;
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h1_0000, 32'h0, HALF, ONE, 1'b1);
    wait_q(4);
    n_tests++; if (q_ez.size() !== 4) begin n_fail++; $display("FAIL basic_count: got %0d beats, required 4", q_ez.size()); end
    for (int i = 0; i < 4 && i < q_ez.size(); i++) begin
      n_tests++; if (q_ez[i] !== exp_ez[i]) begin n_fail++; $display("FAIL basic_ez[%0d]: got %h, required %h", i, q_ez[i], exp_ez[i]); end
      n_tests++; if (q_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b, required %b", i, q_last[i], (i == 3)); end
    end
    n_tests++; if (t_valid - t_first !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, required 3", t_valid - t_first); end
    n_tests++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL basic_row_err: got %b, required 0", row_err); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_ez [4] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_0000};
    clear_q();
    glitch    = 0;
    toggle_en = 1'b1;
    send_row1();
    wait_q(4);
    idle(12);
    toggle_en   = 1'b0;
    bus.m_ready = 1'b1;
    idle(2);
    n_tests++; if (q_ez.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d beats, required 4", q_ez.size()); end
    for (int i = 0; i < 4 && i < q_ez.size(); i++) begin
      n_tests++; if (q_ez[i] !== exp_ez[i]) begin n_fail++; $display("FAIL stall_ez[%0d]: got %h, required %h", i, q_ez[i], exp_ez[i]); end
    end
    n_tests++; if (glitch !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes while stalled, required 0", glitch); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ez [8] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_0000,
                                32'h0007_0000, 32'h0003_0000, 32'h0002_0000, 32'h0003_0000};
    clear_q();
    send(32'h2_0000, 32'h0, HALF, ONE, 1'b0);
    t_first = t_acc;
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h3_0000, 32'h0, HALF, ONE, 1'b0);
    send(32'h1_0000, 32'h0, HALF, ONE, 1'b1);
    send(32'h5_0000, 32'h4_0000, ONE, HALF, 1'b0);
    send(32'h6_0000, 32'h4_0000, ONE, HALF, 1'b0);
    send(32'h6_0000, 32'h4_0000, ONE, HALF, 1'b0);
    send(32'h7_0000, 32'h4_0000, ONE, HALF, 1'b1);
    n_tests++; if (t_acc - t_first !== 7) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles for 8 beats, required 7", t_acc - t_first); end
    wait_q(8);
    n_tests++; if (q_ez.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d beats, required 8", q_ez.size()); end
    for (int i = 0; i < 8 && i < q_ez.size(); i++) begin
      n_tests++; if (q_ez[i] !== exp_ez[i]) begin n_fail++; $display("FAIL b2b_ez[%0d]: got %h, required %h", i, q_ez[i], exp_ez[i]); end
    end
    n_tests++; if (q_last.size() == 8 && q_last[7] !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %b, required 1", q_last[7]); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp0;
    logic        exp_sat;
`ifdef FDTD_EZ_SAT_EN
    exp0    = 32'h7FFF_FFFF;
    exp_sat = 1'b1;
`else
    exp0    = 32'h8001_0000;
    exp_sat = 1'b0;
`endif
    clear_q();
    send(32'h2_0000, 32'h7FFF_0000, ONE, ONE, 1'b0);
    send(32'h2_0000, 32'h0, ONE, ONE, 1'b0);
    send(32'h2_0000, 32'h0, ONE, ONE, 1'b0);
    send(32'h2_0000, 32'h0, ONE, ONE, 1'b1);
    wait_q(4);
    n_tests++; if (q_ez.size() !== 4) begin n_fail++; $display("FAIL sat_count: got %0d beats, required 4", q_ez.size()); end
    if (q_ez.size() == 4) begin
      n_tests++; if (q_ez[0] !== exp0) begin n_fail++; $display("FAIL sat_ez: got %h, required %h", q_ez[0], exp0); end
      n_tests++; if (q_sat[0] !== exp_sat) begin n_fail++; $display("FAIL sat_flag: got %b, required %b", q_sat[0], exp_sat); end
      n_tests++; if (q_ez[1] !== 32'h0 || q_sat[1] !== 1'b0) begin n_fail++; $display("FAIL sat_next: got %h/%b, required 0/0", q_ez[1], q_sat[1]); end
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_row_err();
    clear_q();
    send(32'h1_0000, 32'h0, ONE, 32'h0, 1'b0);
    send(32'h3_0000, 32'h0, ONE, 32'h0, 1'b1);
    n_tests++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL early_last_row_err: got %b, required 1", row_err); end
    send(32'h1_0000, 32'h0, ONE, 32'h0, 1'b0);
    wait_q(3);
    n_tests++; if (q_ez.size() !== 3) begin n_fail++; $display("FAIL early_count: got %0d beats, required 3", q_ez.size()); end
    if (q_ez.size() == 3) begin
      n_tests++; if (q_ez[1] !== 32'h0002_0000) begin n_fail++; $display("FAIL early_ez1: got %h, required 00020000", q_ez[1]); end
      n_tests++; if (q_ez[2] !== 32'h0001_0000) begin n_fail++; $display("FAIL early_cell0: got %h, required 00010000", q_ez[2]); end
    end
    pulse_clr();
    n_tests++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL clr_row_err: got %b, required 0", row_err); end
    for (int i = 0; i < 3; i++) send(32'h0, 32'h0, ONE, ONE, 1'b0);
    n_tests++; if (row_err !== 1'b0) begin n_fail++; $display("FAIL long_row_early: got %b, required 0", row_err); end
    send(32'h0, 32'h0, ONE, ONE, 1'b0);
    send(32'h0, 32'h0, ONE, ONE, 1'b0);
    n_tests++; if (row_err !== 1'b1) begin n_fail++; $display("FAIL long_row_err: got %b, required 1", row_err); end
    wait_q(8);
    pulse_clr();
  endtask

  task automatic test_rst_flush();
    bus.m_ready = 1'b0;
    send(32'h1_0000, 32'h0, ONE, ONE, 1'b0);
    send(32'h2_0000, 32'h0, ONE, ONE, 1'b0);
    idle(4);
    n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup_valid: got %b, required 1", bus.m_valid); end
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b, required 0", bus.m_valid); end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.m_ready = 1'b1;
    clear_q();
    idle(10);
    n_tests++; if (q_ez.size() !== 0) begin n_fail++; $display("FAIL rst_flush_beats: got %0d beats, required 0", q_ez.size()); end
  endtask

  task automatic test_clr_flush();
    bus.m_ready = 1'b0;
    send(32'h1_0000, 32'h0, ONE, ONE, 1'b0);
    send(32'h2_0000, 32'h0, ONE, ONE, 1'b0);
    idle(4);
    clr         = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL clr_before_edge: got %b, required 1", bus.m_valid); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_after_edge: got %b, required 0", bus.m_valid); end
    bus.m_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL clr_s_ready: got %b, required 0", bus.s_ready); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    clear_q();
    idle(10);
    n_tests++; if (q_ez.size() !== 0) begin n_fail++; $display("FAIL clr_flush_beats: got %0d beats, required 0", q_ez.size()); end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    glitch      = 0;
    toggle_en   = 1'b0;
    prev_stall  = 1'b0;
    seen_valid  = 1'b0;
    rst         = 1'b1;
    clr         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_hy    = '0;
    bus.s_ez    = '0;
    bus.s_cezhy = '0;
    bus.s_ceze  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic_row();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_row_err();
    test_rst_flush();
    test_clr_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
